// File: rtl/rx_fifo_pkg.sv
// Shared constants and pointer helper for the packet-aware receive FIFO.
package rx_fifo_pkg;

   localparam int RX_FIFO_DEF_WIDTH = 8;
   localparam int RX_FIFO_DEF_DEPTH = 8;

   // Widest pointer needed (DEPTH up to 256 -> 8 address bits + wrap bit).
   localparam int unsigned RX_FIFO_PTR_MAX_W = 9;

   // Wrapped occupancy a - b, reduced modulo 2^w where w is the real pointer width.
   function automatic logic [RX_FIFO_PTR_MAX_W-1:0] ptr_diff(
      input logic [RX_FIFO_PTR_MAX_W-1:0] a,
      input logic [RX_FIFO_PTR_MAX_W-1:0] b,
      input int unsigned                  w
   );
      logic [RX_FIFO_PTR_MAX_W-1:0] mask;
      for (int unsigned i = 0; i < RX_FIFO_PTR_MAX_W; i++) begin
         mask[i] = (i < w);
      end
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module rx_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo_pkt.sv
// Packet-aware receive FIFO: written bytes become readable only after pkt_commit; pkt_abort drops them.
// Build with RX_FIFO_ERR_FLAGS_EN defined to get sticky overflow/underflow registers.
module rx_fifo_pkt
   import rx_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = RX_FIFO_DEF_WIDTH,
   parameter int DEPTH         = RX_FIFO_DEF_DEPTH,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     w_enable,
   input  logic [DATA_WIDTH-1:0]    w_data,
   input  logic                     pkt_commit,
   input  logic                     pkt_abort,
   input  logic                     r_enable,
   output logic [DATA_WIDTH-1:0]    r_data,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   logic [RX_FIFO_PTR_MAX_W-1:0] occ_spec;
   logic [RX_FIFO_PTR_MAX_W-1:0] occ_cmt;
   logic                         wr_acc, rd_acc, mem_we;
   logic [DATA_WIDTH-1:0]        mem_rdata;

   // Speculative occupancy counts uncommitted bytes; committed occupancy is what the reader sees.
   assign occ_spec = ptr_diff(RX_FIFO_PTR_MAX_W'(wr_ptr_q), RX_FIFO_PTR_MAX_W'(rd_ptr_q), PTR_W);
   assign occ_cmt  = ptr_diff(RX_FIFO_PTR_MAX_W'(cmt_ptr_q), RX_FIFO_PTR_MAX_W'(rd_ptr_q), PTR_W);

   assign full         = (occ_spec == RX_FIFO_PTR_MAX_W'(DEPTH));
   assign empty        = (occ_cmt == '0);
   assign count        = occ_cmt[PTR_W-1:0];
   assign almost_full  = (occ_spec >= RX_FIFO_PTR_MAX_W'(AFULL_THRESH));
   assign almost_empty = (occ_cmt <= RX_FIFO_PTR_MAX_W'(AEMPTY_THRESH));

   assign wr_acc = w_enable && !full;
   assign rd_acc = r_enable && !empty;
   assign mem_we = wr_acc && !clear && !pkt_abort;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      cmt_ptr_d = cmt_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (clear) begin
         wr_ptr_d  = '0;
         cmt_ptr_d = '0;
         rd_ptr_d  = '0;
      end else begin
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (pkt_abort) begin
            wr_ptr_d = cmt_ptr_q;
         end else begin
            if (wr_acc) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
            // Commit covers a write accepted in the same cycle.
            if (pkt_commit) begin
               cmt_ptr_d = wr_ptr_d;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         cmt_ptr_q <= '0;
         rd_ptr_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         cmt_ptr_q <= cmt_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

`ifdef RX_FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clear) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (w_enable && full && !pkt_abort) begin
            overflow_d = 1'b1;
         end
         if (r_enable && empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   rx_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (w_data),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (mem_rdata)
   );

   assign r_data = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_rx_fifo_pkt.sv
// Scoreboard bench for rx_fifo_pkt: one DEPTH=8 and one DEPTH=4 instance driven with identical stimulus.
module tb_rx_fifo_pkt;

`ifdef RX_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       clear, w_enable, pkt_commit, pkt_abort, r_enable;
   logic [7:0] w_data;

   logic [7:0] r_data_a, r_data_b;
   logic       empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
   logic       empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
   logic [3:0] count_a;
   logic [2:0] count_b;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] sb_c [2][$];
   logic [7:0] sb_u [2][$];
   bit         m_ovf [2];
   bit         m_udf [2];
   int         m_depth [2] = '{8, 4};
   int         m_af    [2] = '{6, 3};
   int         m_ae    [2] = '{1, 1};

   always #5 clk = ~clk;

   rx_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
      .pkt_commit(pkt_commit), .pkt_abort(pkt_abort), .r_enable(r_enable),
      .r_data(r_data_a), .empty(empty_a), .full(full_a), .almost_empty(ae_a),
      .almost_full(af_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a)
   );

   rx_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut4 (
      .clk(clk), .rst(rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
      .pkt_commit(pkt_commit), .pkt_abort(pkt_abort), .r_enable(r_enable),
      .r_data(r_data_b), .empty(empty_b), .full(full_b), .almost_empty(ae_b),
      .almost_full(af_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   task automatic sample(input int d, output int rd, output int emp, output int ful,
                         output int ae, output int af, output int cnt, output int ovf, output int udf);
      if (d == 0) begin
         rd = r_data_a; emp = empty_a; ful = full_a; ae = ae_a; af = af_a;
         cnt = count_a; ovf = ovf_a; udf = udf_a;
      end else begin
         rd = r_data_b; emp = empty_b; ful = full_b; ae = ae_b; af = af_b;
         cnt = count_b; ovf = ovf_b; udf = udf_b;
      end
   endtask

   task automatic check_state(input int d);
      int rd, emp, ful, ae, af, cnt, ovf, udf, nc, occ;
      sample(d, rd, emp, ful, ae, af, cnt, ovf, udf);
      nc  = sb_c[d].size();
      occ = nc + sb_u[d].size();
      check($sformatf("count[%0d]", d), cnt, nc);
      check($sformatf("empty[%0d]", d), emp, int'(nc == 0));
      check($sformatf("full[%0d]", d), ful, int'(occ == m_depth[d]));
      check($sformatf("almost_empty[%0d]", d), ae, int'(nc <= m_ae[d]));
      check($sformatf("almost_full[%0d]", d), af, int'(occ >= m_af[d]));
      check($sformatf("overflow[%0d]", d), ovf, ERR_EN ? int'(m_ovf[d]) : 0);
      check($sformatf("underflow[%0d]", d), udf, ERR_EN ? int'(m_udf[d]) : 0);
      check($sformatf("r_data[%0d]", d), rd, (nc == 0) ? 0 : int'(sb_c[d][0]));
   endtask

   task automatic check_reset_vals(input string tag);
      int rd, emp, ful, ae, af, cnt, ovf, udf;
      for (int d = 0; d < 2; d++) begin
         sample(d, rd, emp, ful, ae, af, cnt, ovf, udf);
         check($sformatf("%s_empty[%0d]", tag, d), emp, 1);
         check($sformatf("%s_full[%0d]", tag, d), ful, 0);
         check($sformatf("%s_count[%0d]", tag, d), cnt, 0);
         check($sformatf("%s_aempty[%0d]", tag, d), ae, 1);
         check($sformatf("%s_afull[%0d]", tag, d), af, 0);
         check($sformatf("%s_ovf[%0d]", tag, d), ovf, 0);
         check($sformatf("%s_udf[%0d]", tag, d), udf, 0);
         check($sformatf("%s_rdata[%0d]", tag, d), rd, 0);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         sb_c[d].delete();
         sb_u[d].delete();
         m_ovf[d] = 1'b0;
         m_udf[d] = 1'b0;
      end
   endtask

   // Drive one cycle; the model is advanced from the pre-edge state, outputs checked after the edge.
   task automatic cycle(input bit we, input logic [7:0] wd, input bit cm, input bit ab,
                        input bit re, input bit clr);
      int rd, emp, ful, ae, af, cnt, ovf, udf, occ;
      logic [7:0] exp_b;
      w_enable = we; w_data = wd; pkt_commit = cm; pkt_abort = ab; r_enable = re; clear = clr;
      for (int d = 0; d < 2; d++) begin
         occ = sb_c[d].size() + sb_u[d].size();
         if (clr) begin
            sb_c[d].delete(); sb_u[d].delete();
            m_ovf[d] = 1'b0; m_udf[d] = 1'b0;
         end else begin
            if (re) begin
               if (sb_c[d].size() > 0) begin
                  exp_b = sb_c[d].pop_front();
                  sample(d, rd, emp, ful, ae, af, cnt, ovf, udf);
                  check($sformatf("pop[%0d]", d), rd, int'(exp_b));
               end else begin
                  m_udf[d] = 1'b1;
               end
            end
            if (ab) begin
               sb_u[d].delete();
            end else begin
               if (we) begin
                  if (occ < m_depth[d]) sb_u[d].push_back(wd);
                  else m_ovf[d] = 1'b1;
               end
               if (cm) begin
                  while (sb_u[d].size() > 0) sb_c[d].push_back(sb_u[d].pop_front());
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check_state(d);
      w_enable = 0; pkt_commit = 0; pkt_abort = 0; r_enable = 0; clear = 0;
   endtask

   initial begin
      rst = 1'b1; clear = 0; w_enable = 0; w_data = 0; pkt_commit = 0; pkt_abort = 0; r_enable = 0;
      model_reset();
      #2;
      check_reset_vals("por");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Three-byte packet committed with its last byte, then drained.
      cycle(1, 8'h11, 0, 0, 0, 0);
      cycle(1, 8'h22, 0, 0, 0, 0);
      cycle(1, 8'h33, 1, 0, 0, 0);
      check("cmt3_count", int'(count_a), 3);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 1, 0);
      cycle(0, 8'h00, 0, 0, 1, 0);

      // Aborted packet leaves nothing visible; next packet goes through.
      for (int i = 0; i < 5; i++) cycle(1, 8'hA0 + 8'(i), 0, 0, 0, 0);
      cycle(0, 8'h00, 0, 1, 0, 0);
      cycle(1, 8'hB0, 1, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0);

      // Fill to full, overflow, then simultaneous read and write while full.
      for (int i = 0; i < 8; i++) cycle(1, 8'h50 + 8'(i), (i == 7), 0, 0, 0);
      cycle(1, 8'h5F, 1, 0, 0, 0);
      cycle(1, 8'h60, 1, 0, 1, 0);
      check("rw_full_count", int'(count_a), 7);
      for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 0, 1, 0);

      // Read and write together while empty: read ignored.
      cycle(1, 8'h70, 0, 0, 1, 0);
      cycle(0, 8'h00, 1, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0);

      // Wrap-around fill/drain; thresholds exercised at every occupancy.
      cycle(0, 8'h00, 0, 0, 0, 1);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) cycle(1, 8'(8'hC0 + 8'(r * 16 + i)), 1, 0, 0, 0);
         for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 0, 1, 0);
      end
      for (int i = 0; i < 40; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
      end

      // Commit and abort together: abort wins, uncommitted bytes discarded.
      cycle(0, 8'h00, 0, 0, 0, 1);
      cycle(1, 8'hD1, 0, 0, 0, 0);
      cycle(1, 8'hD2, 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 1, 0, 0);
      check("cmt_abort_count", int'(count_a), 0);

      // Clear while full, with concurrent write/read/commit.
      for (int i = 0; i < 8; i++) cycle(1, 8'hE0 + 8'(i), 1, 0, 0, 0);
      cycle(1, 8'hEF, 1, 0, 1, 1);
      check_reset_vals("clr");

      // Asynchronous reset mid-packet, between clock edges.
      cycle(1, 8'h91, 1, 0, 0, 0);
      cycle(1, 8'h92, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_vals("arst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      cycle(1, 8'h93, 1, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
